// File: rtl/dpcm_enc_mc.sv
// rtl/dpcm_enc_mc.sv - multi-channel DPCM residual encoder; DPCM_SAT_EN selects clamping instead of wrap-around
module dpcm_enc_mc #(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 4,
  parameter int RES_W    = 16,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_chan,
  input  logic              in_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_res,
  output logic [CH_W-1:0]   out_chan,
  output logic              out_sat,
  output logic              chan_err
);

  // Channel count widened by one bit so the range check also works at powers of two
  localparam logic [CH_W:0] LP_NCH = (CH_W+1)'(CHANNELS);

`ifdef DPCM_SAT_EN
  // Residual limits expressed at the full difference width
  localparam logic signed [DATA_W:0] LP_RES_MAX = {{(DATA_W+2-RES_W){1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] LP_RES_MIN = {{(DATA_W+2-RES_W){1'b1}}, {(RES_W-1){1'b0}}};
`endif

  logic [DATA_W-1:0]        r_pred [CHANNELS];
  logic                     r_out_valid;
  logic [RES_W-1:0]         r_out_res;
  logic [CH_W-1:0]          r_out_chan;
  logic                     r_out_sat;
  logic                     r_chan_err;

  logic                     w_accept;
  logic                     w_chan_ok;
  logic                     w_load;
  logic [DATA_W-1:0]        w_pred_sel;
  logic [DATA_W-1:0]        w_p;
  logic signed [DATA_W:0]   w_diff;
  logic [RES_W-1:0]         w_res;
  logic                     w_sat;

  // No skid buffer: accept only when the output slot is free or being drained now
  assign in_ready  = !rst && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_chan_ok = ({1'b0, in_chan} < LP_NCH);
  assign w_load    = w_accept && w_chan_ok;

  // Predictor lookup as an explicit mux so an out-of-range channel reads 0 rather than X
  always_comb begin
    w_pred_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_chan == CH_W'(i)) begin
        w_pred_sel = r_pred[i];
      end
    end
  end

  // Key samples and clears both encode against zero
  assign w_p    = (in_first || clear) ? '0 : w_pred_sel;
  assign w_diff = $signed({1'b0, in_data}) - $signed({1'b0, w_p});

  // Narrow the difference to the residual width: clamp or wrap depending on build
  always_comb begin
    w_res = RES_W'(w_diff);
    w_sat = 1'b0;
`ifdef DPCM_SAT_EN
    if (w_diff > LP_RES_MAX) begin
      w_res = RES_W'(LP_RES_MAX);
      w_sat = 1'b1;
    end else if (w_diff < LP_RES_MIN) begin
      w_res = RES_W'(LP_RES_MIN);
      w_sat = 1'b1;
    end
`endif
  end

  // Predictor bank: accepted channel takes the sample, clear zeroes every other entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pred[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_load && (in_chan == CH_W'(i))) begin
          r_pred[i] <= in_data;
        end else if (clear) begin
          r_pred[i] <= '0;
        end
      end
    end
  end

  // Output slot: load wins over drain so back-to-back traffic keeps out_valid high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_chan  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_res   <= w_res;
      r_out_chan  <= in_chan;
      r_out_sat   <= w_sat;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // One-cycle flag for a sample that was swallowed because its channel does not exist
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chan_err <= 1'b0;
    end else begin
      r_chan_err <= w_accept && !w_chan_ok;
    end
  end

  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_chan  = r_out_chan;
  assign out_sat   = r_out_sat;
  assign chan_err  = r_chan_err;

endmodule

// File: tb/tb_dpcm_enc_mc.sv
// tb/tb_dpcm_enc_mc.sv - self-checking bench for dpcm_enc_mc (DATA_W=16, CHANNELS=3, RES_W=8)
module tb_dpcm_enc_mc;

  localparam int DATA_W   = 16;
  localparam int CHANNELS = 3;
  localparam int RES_W    = 8;
  localparam int CH_W     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CH_W-1:0]   in_chan = '0;
  logic              in_first = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [RES_W-1:0]  out_res;
  logic [CH_W-1:0]   out_chan;
  logic              out_sat;
  logic              chan_err;

  dpcm_enc_mc #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_chan(in_chan), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_chan(out_chan), .out_sat(out_sat), .chan_err(chan_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r; bit v; int d; int ch; bit f; bit c; bit o;
    bit chk; int res_sat; bit sat_sat; int res_wrap;
  } vec_t;

  typedef struct { int res; int chan; bit sat; } out_t;

  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference state: per-channel previous sample and the pending-output queue
  int   m_pred [CHANNELS];
  out_t m_q [$];
  bit   m_err = 0;
  bit   m_init = 0;

  // Table expectation for the cycle after a table row
  bit   tb_pend = 0;
  int   tb_res;
  int   tb_chan;
  bit   tb_sat;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void resid(input int data, input int p, output int r, output bit s);
    int d;
    d = data - p;
`ifdef DPCM_SAT_EN
    if (d > 127) begin r = 127; s = 1; end
    else if (d < -128) begin r = -128; s = 1; end
    else begin r = d; s = 0; end
`else
    r = d & 255;
    if (r >= 128) r = r - 256;
    s = 0;
`endif
  endfunction

  // One clock: drive inputs, check DUT against the model mid-cycle, advance the model
  task automatic step(input bit r, input bit v, input int d, input int ch,
                      input bit f, input bit c, input bit o);
    bit   rdy;
    bit   acc;
    int   p;
    out_t e;
    rst = r; in_valid = v; in_data = DATA_W'(d); in_chan = CH_W'(ch);
    in_first = f; clear = c; out_ready = o;
    @(negedge clk);
    rdy = !r && ((m_q.size() == 0) || o);
    chk("in_ready", int'(in_ready), int'(rdy));
    if (m_init) begin
      chk("out_valid", int'(out_valid), int'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("out_res", int'($signed(out_res)), m_q[0].res);
        chk("out_chan", int'(out_chan), m_q[0].chan);
        chk("out_sat", int'(out_sat), int'(m_q[0].sat));
      end
      chk("chan_err", int'(chan_err), int'(m_err));
    end
    if (tb_pend) begin
      chk("tbl_valid", int'(out_valid), 1);
      chk("tbl_res", int'($signed(out_res)), tb_res);
      chk("tbl_chan", int'(out_chan), tb_chan);
      chk("tbl_sat", int'(out_sat), int'(tb_sat));
      tb_pend = 0;
    end
    if (r) begin
      m_q.delete();
      foreach (m_pred[i]) m_pred[i] = 0;
      m_err = 0;
      m_init = 1;
    end else begin
      acc = v && rdy;
      if ((m_q.size() != 0) && o) void'(m_q.pop_front());
      m_err = 0;
      if (acc && ch < CHANNELS) begin
        p = (f || c) ? 0 : m_pred[ch];
        resid(d, p, e.res, e.sat);
        e.chan = ch;
        m_q.push_back(e);
        if (c) foreach (m_pred[i]) m_pred[i] = 0;
        m_pred[ch] = d;
      end else begin
        if (acc) m_err = 1;
        if (c) foreach (m_pred[i]) m_pred[i] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [16];
  int   rd;
  int   rch;

  initial begin
    tbl = '{
      '{1,0,0,0,0,0,1, 0,0,0,0},
      '{0,1,100,0,0,0,1, 1,100,0,100},
      '{0,1,130,0,0,0,1, 1,30,0,30},
      '{0,1,90,0,0,0,1, 1,-40,0,-40},
      '{0,1,1000,1,0,0,1, 1,127,1,-24},
      '{0,1,1010,1,0,0,1, 1,10,0,10},
      '{1,0,0,0,0,0,1, 0,0,0,0},
      '{0,1,40,0,0,0,1, 1,40,0,40},
      '{0,1,500,2,0,0,1, 1,127,1,-12},
      '{0,1,45,0,1,0,1, 1,45,0,45},
      '{0,1,498,2,0,0,1, 1,-2,0,-2},
      '{1,0,0,0,0,0,1, 0,0,0,0},
      '{0,1,40,2,0,0,1, 1,40,0,40},
      '{0,1,50,2,0,1,1, 1,50,0,50},
      '{0,1,55,2,0,0,1, 1,5,0,5},
      '{0,1,7,0,0,0,1, 1,7,0,7}
    };

    @(posedge clk); #1;
    // Reset state: sampled after one reset edge while rst is still held
    step(1, 1, 77, 1, 0, 0, 1);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_res", int'(out_res), 0);
    chk("rst_out_chan", int'(out_chan), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_chan_err", int'(chan_err), 0);

    // Test-plan sequences from the vector table
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].ch, tbl[i].f, tbl[i].c, tbl[i].o);
      if (tbl[i].chk) begin
        tb_pend = 1;
        tb_chan = tbl[i].ch;
`ifdef DPCM_SAT_EN
        tb_res = tbl[i].res_sat;
        tb_sat = tbl[i].sat_sat;
`else
        tb_res = tbl[i].res_wrap;
        tb_sat = 0;
`endif
      end
    end
    step(0, 0, 0, 0, 0, 0, 1);

    // Backpressure: one residual held for three cycles, then both drain in order
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 5, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8, 1, 0, 0, 0);
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_hold", int'($signed(out_res)), 5);
    end
    step(0, 1, 8, 1, 0, 0, 1);
    chk("bp_next", int'($signed(out_res)), 3);
    chk("bp_next_valid", int'(out_valid), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("bp_empty", int'(out_valid), 0);

    // Out-of-range channel: swallowed, one error pulse, no output
    step(0, 1, 9, 3, 0, 0, 1);
    chk("err_pulse", int'(chan_err), 1);
    chk("err_no_out", int'(out_valid), 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("err_once", int'(chan_err), 0);

    // Reset while an output is stalled drops it and forgets history
    step(0, 1, 33, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_drop", int'(out_valid), 0);
    step(0, 1, 20, 0, 0, 0, 1);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_res", int'($signed(out_res)), 20);
    step(0, 0, 0, 0, 0, 0, 1);

    // Random traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      rch = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        rd = int'($urandom_range(0, 65535));
      end else begin
        rd = m_pred[rch % CHANNELS] + int'($urandom_range(0, 300)) - 150;
        if (rd < 0) rd = 0;
        if (rd > 65535) rd = 65535;
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rd, rch,
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
